// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Groups the control unit's datapath/memory-facing signals.
//   master : the control FSM (drives strobes and selects, reads opcode/flags/readies)
//   slave  : the datapath and memories (drive opcode/flags/readies, consume strobes)
//   CNT_WIDTH must match the CNT_WIDTH of the attached multicycle_control.
interface multicycle_control_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           opcode;
  logic                 branch_taken;
  logic                 imem_ready;
  logic                 dmem_ready;
  logic                 imem_req;
  logic                 dmem_req;
  logic                 dmem_we;
  logic                 ir_write;
  logic                 pc_write;
  logic [1:0]           pc_src;
  logic [1:0]           alu_src_a;
  logic                 alu_src_b;
  logic [1:0]           alu_op;
  logic                 reg_write;
  logic [1:0]           wb_sel;
  logic [2:0]           state;
  logic                 trap;
  logic [1:0]           trap_cause;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] instret_cnt;

  modport master (
    input  opcode, branch_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, state,
           trap, trap_cause, cycle_cnt, instret_cnt
  );

  modport slave (
    output opcode, branch_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, state,
           trap, trap_cause, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Sequencing FSM for the multi-cycle RV32I core. Steps the shared datapath
//   through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, waits on variable-latency
//   instruction/data memories, traps on illegal opcodes or memory timeouts,
//   and keeps cycle / retired-instruction counters.
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset
//   bus  - multicycle_control_if.master: opcode, branch_taken, imem_ready,
//          dmem_ready in; memory requests, datapath strobes/selects, debug
//          state, trap flag/cause and the two counters out.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  multicycle_control_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_e;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_e               state_q, state_d;
  logic                 trap_q, trap_d;
  logic [1:0]           cause_q, cause_d;
  logic [15:0]          wait_q, wait_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 retire;

  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic legal;

  assign is_r      = (bus.opcode == OP_R);
  assign is_i      = (bus.opcode == OP_I);
  assign is_load   = (bus.opcode == OP_LOAD);
  assign is_store  = (bus.opcode == OP_STORE);
  assign is_branch = (bus.opcode == OP_BRANCH);
  assign is_jal    = (bus.opcode == OP_JAL);
  assign is_jalr   = (bus.opcode == OP_JALR);
  assign is_lui    = (bus.opcode == OP_LUI);
  assign is_auipc  = (bus.opcode == OP_AUIPC);
  assign legal     = is_r | is_i | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  // Next-state, trap, wait-counter and performance-counter logic
  always_comb begin
    state_d   = state_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    wait_d    = wait_q;
    retire    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // A ready on the limit cycle still wins over the timeout.
        if (bus.imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == TIMEOUT) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end
      end
      S_EXECUTE: begin
        if (is_branch) begin
          state_d = S_FETCH;
          wait_d  = 16'd0;
          retire  = 1'b1;
        end else if (is_load || is_store) begin
          state_d = S_MEMORY;
          wait_d  = 16'd0;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (bus.dmem_ready) begin
          if (is_store) begin
            state_d = S_FETCH;
            wait_d  = 16'd0;
            retire  = 1'b1;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == TIMEOUT) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b11;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        wait_d  = 16'd0;
        retire  = 1'b1;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
        wait_d  = 16'd0;
      end
    endcase
    cycle_d   = (state_q != S_TRAP) ? cycle_q + CNT_WIDTH'(1) : cycle_q;
    instret_d = retire ? instret_q + CNT_WIDTH'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
      wait_q    <= 16'd0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Strobe/select decode. Gated by rstn so requests drop the instant reset
  // is asserted, even though the reset state (FETCH) would otherwise request.
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = 2'b00;
    bus.alu_src_a = 2'b00;
    bus.alu_src_b = 1'b0;
    bus.alu_op    = 2'b00;
    bus.reg_write = 1'b0;
    bus.wb_sel    = 2'b00;
    if (rstn) begin
      unique case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          if (bus.imem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        S_EXECUTE: begin
          if (is_r) begin
            bus.alu_op = 2'b10;
          end else if (is_i) begin
            bus.alu_src_b = 1'b1;
            bus.alu_op    = 2'b10;
          end else if (is_lui) begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 1'b1;
          end else if (is_auipc) begin
            bus.alu_src_a = 2'b01;
            bus.alu_src_b = 1'b1;
          end else if (is_load || is_store) begin
            bus.alu_src_b = 1'b1;
          end else if (is_branch) begin
            bus.alu_op   = 2'b01;
            bus.pc_write = bus.branch_taken;
            bus.pc_src   = 2'b01;
          end else if (is_jal) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'b01;
          end else if (is_jalr) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'b10;
          end
        end
        S_MEMORY: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = is_store;
        end
        S_WRITEBACK: begin
          bus.reg_write = 1'b1;
          if (is_load) begin
            bus.wb_sel = 2'b01;
          end else if (is_jal || is_jalr) begin
            bus.wb_sel = 2'b10;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.trap        = trap_q;
  assign bus.trap_cause  = cause_q;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;

endmodule
